// File: rtl/led_breathe.sv
// rtl/led_breathe.sv - breathing-LED PWM driver with a triangle duty ramp
// Optional macro LED_BREATHE_GAMMA_EN selects squared (gamma) duty mapping.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_TICKS = 11719
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  output logic                LEDG_N,
  output logic [PWM_BITS-1:0] DUTY,
  output logic                PEAK
);

  typedef enum logic {RISE, FALL} state_t;

  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);

  state_t                state_q, state_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [SW-1:0]         step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0]   ramp_q, ramp_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  ledg_n_q, ledg_n_d;
  logic                  peak_q, peak_d;
  logic                  step;
  logic [PWM_BITS-1:0]   mapped;
`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
`endif

  always_comb begin
    step       = EN && (step_cnt_q == STEP_LAST);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    step_cnt_d = step_cnt_q;
    if (EN) step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + SW'(1);

    state_d = state_q;
    ramp_d  = ramp_q;
    peak_d  = 1'b0;
    if (step) begin
      case (state_q)
        RISE: begin
          if (ramp_q == MAX) begin
            state_d = FALL;
            ramp_d  = MAX - PWM_BITS'(1);
            peak_d  = 1'b1;
          end else begin
            ramp_d = ramp_q + PWM_BITS'(1);
          end
        end
        default: begin
          if (ramp_q == '0) begin
            state_d = RISE;
            ramp_d  = PWM_BITS'(1);
          end else begin
            ramp_d = ramp_q - PWM_BITS'(1);
          end
        end
      endcase
    end

`ifdef LED_BREATHE_GAMMA_EN
    sq     = {{PWM_BITS{1'b0}}, ramp_q} * {{PWM_BITS{1'b0}}, ramp_q};
    mapped = PWM_BITS'(sq >> PWM_BITS);
`else
    mapped = ramp_q;
`endif

    // Duty only changes at the carrier boundary, using the pre-step ramp.
    duty_d   = (pwm_cnt_q == MAX) ? mapped : duty_q;
    ledg_n_d = !(pwm_cnt_q < duty_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= RISE;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      ramp_q     <= '0;
      duty_q     <= '0;
      ledg_n_q   <= 1'b1;
      peak_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      ramp_q     <= ramp_d;
      duty_q     <= duty_d;
      ledg_n_q   <= ledg_n_d;
      peak_q     <= peak_d;
    end
  end

  assign LEDG_N = ledg_n_q;
  assign DUTY   = duty_q;
  assign PEAK   = peak_q;

endmodule
